// File: rtl/sbox_ti_scheduler.sv
// Arbiter/sequencer for the shared masked S-box inversion pipeline: grants it to the
// data path or key schedule, issues one byte index per cycle and tracks in-flight tags.
module sbox_ti_scheduler #(
    parameter int NB_DATA   = 16,
    parameter int NB_KEY    = 4,
    parameter int LAT       = 2,
    parameter int IDXW      = 4,
    parameter bit KEY_FIRST = 1'b1
) (
    input  logic            CLK,
    input  logic            RSTn,
    input  logic            d_req,
    input  logic            k_req,
    output logic            d_gnt,
    output logic            k_gnt,
    output logic            sel_key,
    output logic            in_vld,
    output logic [IDXW-1:0] in_idx,
    output logic            rnd_en,
    output logic            out_vld,
    output logic [IDXW-1:0] out_idx,
    output logic            out_key,
    output logic            d_done,
    output logic            k_done,
    output logic            busy
);

    if (NB_DATA < 1 || NB_KEY < 1 || LAT < 1 ||
        NB_DATA > 2**IDXW || NB_KEY > 2**IDXW) begin : g_bad_param
        $error("sbox_ti_scheduler: job size does not fit IDXW or LAT < 1");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    typedef struct packed {
        logic            vld;
        logic            key;
        logic [IDXW-1:0] idx;
    } tag_t;

    state_t          state;
    tag_t            tag_pipe [LAT];
    logic            pick_key;
    logic            inner_vld;
    logic            drain_done;
    logic [IDXW-1:0] last_idx;

    assign pick_key = k_req & (KEY_FIRST || !d_req);
    assign last_idx = sel_key ? IDXW'(NB_KEY - 1) : IDXW'(NB_DATA - 1);

    // in_idx doubles as the job counter; sel_key holds the job type while issuing.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state   <= IDLE;
            in_vld  <= 1'b0;
            in_idx  <= '0;
            sel_key <= 1'b0;
            d_gnt   <= 1'b0;
            k_gnt   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_req || k_req) begin
                        state   <= ISSUE;
                        in_vld  <= 1'b1;
                        in_idx  <= '0;
                        sel_key <= pick_key;
                        k_gnt   <= pick_key;
                        d_gnt   <= !pick_key;
                    end
                end
                ISSUE: begin
                    d_gnt <= 1'b0;
                    k_gnt <= 1'b0;
                    if (in_idx == last_idx) begin
                        state   <= DRAIN;
                        in_vld  <= 1'b0;
                        in_idx  <= '0;
                        sel_key <= 1'b0;
                    end else begin
                        in_idx <= in_idx + IDXW'(1);
                    end
                end
                DRAIN: begin
                    if (drain_done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < LAT; i++) tag_pipe[i] <= '0;
        end else begin
            tag_pipe[0] <= '{vld: in_vld, key: sel_key, idx: in_idx};
            for (int i = 1; i < LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    always_comb begin
        inner_vld = 1'b0;
        for (int i = 0; i < LAT - 1; i++) inner_vld = inner_vld | tag_pipe[i].vld;
    end

    assign out_vld = tag_pipe[LAT-1].vld;
    assign out_key = out_vld & tag_pipe[LAT-1].key;
    assign out_idx = out_vld ? tag_pipe[LAT-1].idx : '0;

    // Last tag of the job leaves the pipeline: nothing issued behind it while draining.
    assign drain_done = (state == DRAIN) && out_vld && !inner_vld;
    assign d_done     = drain_done & ~out_key;
    assign k_done     = drain_done & out_key;
    assign rnd_en     = in_vld | inner_vld | out_vld;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_sbox_ti_scheduler.sv
// Directed bench: two schedulers (key-first and data-first) checked cycle by cycle
// against hand-derived job timelines.
module tb_sbox_ti_scheduler;

    logic       CLK = 1'b0;
    logic       RSTn = 1'b0;
    logic       d_req1 = 1'b1, k_req1 = 1'b1, d_req0 = 1'b1, k_req0 = 1'b1;

    logic       d_gnt1, k_gnt1, sel_key1, in_vld1, rnd_en1, out_vld1, out_key1, d_done1, k_done1, busy1;
    logic [3:0] in_idx1, out_idx1;
    logic       d_gnt0, k_gnt0, sel_key0, in_vld0, rnd_en0, out_vld0, out_key0, d_done0, k_done0, busy0;
    logic [3:0] in_idx0, out_idx0;
    logic [17:0] obs1, obs0;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    sbox_ti_scheduler #(.NB_DATA(16), .NB_KEY(4), .LAT(2), .IDXW(4), .KEY_FIRST(1'b1)) dut1 (
        .CLK(CLK), .RSTn(RSTn), .d_req(d_req1), .k_req(k_req1),
        .d_gnt(d_gnt1), .k_gnt(k_gnt1), .sel_key(sel_key1), .in_vld(in_vld1), .in_idx(in_idx1),
        .rnd_en(rnd_en1), .out_vld(out_vld1), .out_idx(out_idx1), .out_key(out_key1),
        .d_done(d_done1), .k_done(k_done1), .busy(busy1));

    sbox_ti_scheduler #(.NB_DATA(16), .NB_KEY(4), .LAT(2), .IDXW(4), .KEY_FIRST(1'b0)) dut0 (
        .CLK(CLK), .RSTn(RSTn), .d_req(d_req0), .k_req(k_req0),
        .d_gnt(d_gnt0), .k_gnt(k_gnt0), .sel_key(sel_key0), .in_vld(in_vld0), .in_idx(in_idx0),
        .rnd_en(rnd_en0), .out_vld(out_vld0), .out_idx(out_idx0), .out_key(out_key0),
        .d_done(d_done0), .k_done(k_done0), .busy(busy0));

    assign obs1 = {busy1, rnd_en1, d_gnt1, k_gnt1, sel_key1, in_vld1, in_idx1,
                   out_vld1, out_idx1, out_key1, d_done1, k_done1};
    assign obs0 = {busy0, rnd_en0, d_gnt0, k_gnt0, sel_key0, in_vld0, in_idx0,
                   out_vld0, out_idx0, out_key0, d_done0, k_done0};

    // Expected outputs at cycle c of a job granted at cycle g (4 key / 16 data bytes, 2-cycle latency).
    function automatic logic [17:0] jobv(input int c, input int g, input bit key);
        int n = key ? 4 : 16;
        bit iss = (c >= g) && (c < g + n);
        bit outv = (c >= g + 2) && (c < g + n + 2);
        bit act = (c >= g) && (c <= g + n + 1);
        bit fin = (c == g + n + 1);
        logic [17:0] v = '0;
        v[17]   = act;
        v[16]   = act;
        v[15]   = iss && (c == g) && !key;
        v[14]   = iss && (c == g) && key;
        v[13]   = iss && key;
        v[12]   = iss;
        v[11:8] = iss ? 4'(c - g) : 4'd0;
        v[7]    = outv;
        v[6:3]  = outv ? 4'(c - g - 2) : 4'd0;
        v[2]    = outv && key;
        v[1]    = fin && !key;
        v[0]    = fin && key;
        return v;
    endfunction

    task automatic chk(input string tag, input int c, input logic [17:0] obs, input logic [17:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s c%0d: observed %05h expected %05h", tag, c, obs, exp);
        end
    endtask

    initial begin
        // held in reset with both requests high
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("rst_k1", i, obs1, 18'h0);
            chk("rst_k0", i, obs0, 18'h0);
        end

        // release; tie at cycle 0; requesters drop req on their grant
        for (int c = 0; c <= 28; c++) begin
            @(negedge CLK);
            if (c == 0) RSTn = 1'b1;
            chk("tie_keyfirst", c, obs1, jobv(c, 1, 1'b1) | jobv(c, 8, 1'b0));
            chk("tie_datafirst", c, obs0, jobv(c, 1, 1'b0) | jobv(c, 20, 1'b1));
            if (d_gnt1) d_req1 = 1'b0;
            if (k_gnt1) k_req1 = 1'b0;
            if (d_gnt0) d_req0 = 1'b0;
            if (k_gnt0) k_req0 = 1'b0;
        end

        // single data job
        for (int c = 0; c <= 21; c++) begin
            @(negedge CLK);
            if (c == 0) begin d_req1 = 1'b1; d_req0 = 1'b1; end
            chk("data1", c, obs1, jobv(c, 1, 1'b0));
            chk("data0", c, obs0, jobv(c, 1, 1'b0));
            if (d_gnt1) d_req1 = 1'b0;
            if (d_gnt0) d_req0 = 1'b0;
        end

        // key request held for 20 cycles: back-to-back jobs with one idle cycle between
        for (int c = 0; c <= 24; c++) begin
            @(negedge CLK);
            if (c == 0) begin k_req1 = 1'b1; k_req0 = 1'b1; end
            chk("khold1", c, obs1, jobv(c, 1, 1'b1) | jobv(c, 8, 1'b1) | jobv(c, 15, 1'b1));
            chk("khold0", c, obs0, jobv(c, 1, 1'b1) | jobv(c, 8, 1'b1) | jobv(c, 15, 1'b1));
            if (c == 20) begin k_req1 = 1'b0; k_req0 = 1'b0; end
        end

        // reset in the middle of a data job at in_idx 7
        for (int c = 0; c <= 8; c++) begin
            @(negedge CLK);
            if (c == 0) begin d_req1 = 1'b1; d_req0 = 1'b1; end
            chk("mid_pre1", c, obs1, jobv(c, 1, 1'b0));
            chk("mid_pre0", c, obs0, jobv(c, 1, 1'b0));
            if (d_gnt1) d_req1 = 1'b0;
            if (d_gnt0) d_req0 = 1'b0;
        end
        RSTn = 1'b0;
        #1;
        chk("mid_rst1", 8, obs1, 18'h0);
        chk("mid_rst0", 8, obs0, 18'h0);
        d_req1 = 1'b1;
        d_req0 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            chk("mid_hold1", i, obs1, 18'h0);
            chk("mid_hold0", i, obs0, 18'h0);
        end
        for (int c = 0; c <= 21; c++) begin
            @(negedge CLK);
            if (c == 0) RSTn = 1'b1;
            chk("restart1", c, obs1, jobv(c, 1, 1'b0));
            chk("restart0", c, obs0, jobv(c, 1, 1'b0));
            if (d_gnt1) d_req1 = 1'b0;
            if (d_gnt0) d_req0 = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
